// File: rtl/game_pkg.sv
// Shared game-state codes and default timing constants.
// Imported by the game FSM and the start/end overlay stage.
package game_pkg;

   typedef enum logic [1:0] {
      GAME_START = 2'd0,
      GAME_PLAY  = 2'd1,
      GAME_END   = 2'd2
   } game_state_t;

   localparam int DEF_DEBOUNCE_FRAMES = 3;
   localparam int DEF_END_HOLD_FRAMES = 120;

endpackage

// File: rtl/game_fsm_btn_debounce.sv
// Start button conditioner: 2-FF sync, frame-paced debounce, press edge.
// Ports: clk, rst (sync, active-high), tick, btn_raw -> press (1-cycle pulse).
module btn_debounce
   import game_pkg::*;
#(
   parameter int DEBOUNCE_FRAMES = DEF_DEBOUNCE_FRAMES
) (
   input  logic clk,
   input  logic rst,
   input  logic tick,
   input  logic btn_raw,
   output logic press
);

   localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_FRAMES);

   logic [1:0]    sync_ff;
   logic          sync;
   logic          deb;
   logic          deb_q;
   logic [CW-1:0] deb_cnt;

   assign sync = sync_ff[1];

   // deb and deb_q reset high so a button held through reset
   // looks already pressed and never yields a press edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_ff <= '0;
         deb     <= 1'b1;
         deb_q   <= 1'b1;
         deb_cnt <= '0;
         press   <= 1'b0;
      end else begin
         sync_ff <= {sync_ff[0], btn_raw};
         deb_q   <= deb;
         press   <= deb & ~deb_q;
         if (tick) begin
            if (sync != deb) begin
               if (deb_cnt + CW'(1) == CNT_MAX) begin
                  deb     <= sync;
                  deb_cnt <= '0;
               end else begin
                  deb_cnt <= deb_cnt + CW'(1);
               end
            end else begin
               deb_cnt <= '0;
            end
         end
      end
   end

endmodule

// File: rtl/game_fsm.sv
// Game state controller: START -> PLAY -> END -> START, frame-paced.
// Ports: clk, rst, vsync, btn_start, player_dead, boss_dead -> game_active, game_start, game_won.
module game_fsm
   import game_pkg::*;
#(
   parameter int DEBOUNCE_FRAMES = DEF_DEBOUNCE_FRAMES,
   parameter int END_HOLD_FRAMES = DEF_END_HOLD_FRAMES
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       vsync,
   input  logic       btn_start,
   input  logic       player_dead,
   input  logic       boss_dead,
   output logic [1:0] game_active,
   output logic       game_start,
   output logic       game_won
);

   localparam int HW = $clog2(END_HOLD_FRAMES + 1);
   localparam logic [HW-1:0] HOLD_MAX = HW'(END_HOLD_FRAMES);

   game_state_t   state;
   logic          vsync_prev;
   logic          tick;
   logic          press;
   logic [HW-1:0] hold_cnt;

   assign tick        = vsync & ~vsync_prev;
   assign game_active = state;

   btn_debounce #(
      .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
   ) u_deb (
      .clk    (clk),
      .rst    (rst),
      .tick   (tick),
      .btn_raw(btn_start),
      .press  (press)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= GAME_START;
         game_start <= 1'b0;
         game_won   <= 1'b0;
         hold_cnt   <= '0;
         vsync_prev <= 1'b0;
      end else begin
         vsync_prev <= vsync;
         game_start <= 1'b0;
         case (state)
            GAME_START: begin
               if (press) begin
                  state      <= GAME_PLAY;
                  game_start <= 1'b1;
               end
            end
            GAME_PLAY: begin
               if (player_dead | boss_dead) begin
                  state    <= GAME_END;
                  game_won <= boss_dead & ~player_dead;
                  hold_cnt <= '0;
               end
            end
            GAME_END: begin
               // Early presses are dropped, not remembered.
               if (press && hold_cnt == HOLD_MAX) begin
                  state    <= GAME_START;
                  game_won <= 1'b0;
               end else if (tick && hold_cnt != HOLD_MAX) begin
                  hold_cnt <= hold_cnt + HW'(1);
               end
            end
            default: begin
               state    <= GAME_START;
               game_won <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_game_fsm.sv
// Self-checking bench for game_fsm with short debounce/hold settings.
// Directed phases plus randomized games against an event-level model.
module tb_game_fsm;
   import game_pkg::*;

   localparam int DEB  = 2;
   localparam int HOLD = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       vsync;
   logic       btn_start;
   logic       player_dead;
   logic       boss_dead;
   logic [1:0] game_active;
   logic       game_start;
   logic       game_won;

   int   tests = 0;
   int   fails = 0;
   int   starts = 0;
   int   exp_starts = 0;
   bit   mon_on = 1'b0;
   logic start_q = 1'b0;
   logic [1:0] active_q = 2'd0;

   game_fsm #(
      .DEBOUNCE_FRAMES(DEB),
      .END_HOLD_FRAMES(HOLD)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .vsync      (vsync),
      .btn_start  (btn_start),
      .player_dead(player_dead),
      .boss_dead  (boss_dead),
      .game_active(game_active),
      .game_start (game_start),
      .game_won   (game_won)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (mon_on) begin
         if (game_start) begin
            starts++;
            chk("start_from_idle", active_q, GAME_START);
            chk("start_with_play", game_active, GAME_PLAY);
            chk("start_width", start_q, 1'b0);
         end
         start_q  = game_start;
         active_q = game_active;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One frame: low gap of random length, then a 2-cycle vsync pulse.
   task automatic frames(input int n);
      repeat (n) begin
         vsync = 1'b0;
         cyc($urandom_range(4, 8));
         vsync = 1'b1;
         cyc(2);
      end
   endtask

   task automatic press_hold();
      btn_start = 1'b1;
      frames(DEB);
      cyc(3);
   endtask

   task automatic release_btn();
      btn_start = 1'b0;
      frames(DEB);
      cyc(3);
   endtask

   task automatic kill(input logic p, input logic b);
      player_dead = p;
      boss_dead   = b;
      cyc(1);
      player_dead = 1'b0;
      boss_dead   = 1'b0;
   endtask

   initial begin
      logic [1:0] r;
      int ticks;
      int extra;

      rst = 1'b1;
      vsync = 1'b0;
      btn_start = 1'b1;
      player_dead = 1'b0;
      boss_dead = 1'b0;
      cyc(3);
      chk("rst_active", game_active, GAME_START);
      chk("rst_start", game_start, 1'b0);
      chk("rst_won", game_won, 1'b0);
      rst = 1'b0;
      mon_on = 1'b1;

      frames(10);
      chk("held_thru_rst", game_active, GAME_START);
      chk("held_no_press", starts, exp_starts);

      kill(1'b1, 1'b0);
      chk("start_pdead", game_active, GAME_START);
      cyc($urandom_range(1, 5));
      kill(1'b0, 1'b1);
      chk("start_bdead", game_active, GAME_START);
      cyc($urandom_range(1, 5));
      kill(1'b1, 1'b1);
      chk("start_both", game_active, GAME_START);

      release_btn();
      chk("release_idle", game_active, GAME_START);

      btn_start = 1'b1;
      frames(1);
      btn_start = 1'b0;
      frames(3);
      cyc(3);
      chk("glitch_active", game_active, GAME_START);
      chk("glitch_starts", starts, exp_starts);

      press_hold();
      exp_starts++;
      chk("press_play", game_active, GAME_PLAY);
      chk("press_starts", starts, exp_starts);

      release_btn();
      press_hold();
      release_btn();
      chk("play_press_ign", game_active, GAME_PLAY);
      chk("play_no_restart", starts, exp_starts);

      kill(1'b0, 1'b1);
      chk("boss_end", game_active, GAME_END);
      chk("boss_won", game_won, 1'b1);

      press_hold();
      chk("early_press", game_active, GAME_END);
      chk("early_won", game_won, 1'b1);
      release_btn();
      press_hold();
      chk("late_press", game_active, GAME_START);
      chk("late_won", game_won, 1'b0);

      release_btn();
      press_hold();
      exp_starts++;
      chk("replay", game_active, GAME_PLAY);
      chk("replay_starts", starts, exp_starts);

      release_btn();
      kill(1'b1, 1'b1);
      chk("both_end", game_active, GAME_END);
      chk("both_lost", game_won, 1'b0);
      frames(HOLD + 3);
      press_hold();
      chk("sat_press", game_active, GAME_START);

      release_btn();
      press_hold();
      exp_starts++;
      chk("play_again", game_active, GAME_PLAY);

      rst = 1'b1;
      cyc(1);
      chk("midrst_active", game_active, GAME_START);
      chk("midrst_start", game_start, 1'b0);
      rst = 1'b0;
      frames(5);
      cyc(3);
      chk("midrst_held", game_active, GAME_START);
      chk("midrst_starts", starts, exp_starts);

      for (int i = 0; i < 6; i++) begin
         release_btn();
         press_hold();
         exp_starts++;
         chk("rnd_play", game_active, GAME_PLAY);
         release_btn();
         cyc($urandom_range(1, 20));
         r = 2'($urandom_range(1, 3));
         kill(r[0], r[1]);
         chk("rnd_end", game_active, GAME_END);
         chk("rnd_won", game_won, r[1] & ~r[0]);
         extra = int'($urandom_range(0, 3));
         frames(extra);
         ticks = extra + DEB;
         press_hold();
         chk("rnd_press", game_active,
             (ticks >= HOLD) ? GAME_START : GAME_END);
         if (ticks < HOLD) begin
            release_btn();
            press_hold();
            chk("rnd_retry", game_active, GAME_START);
         end
         chk("rnd_won_clr", game_won, 1'b0);
      end

      cyc(3);
      chk("total_starts", starts, exp_starts);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
